// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter: shares one single-port RAM between the instruction-fetch path and the
// load/store data path. Data has fixed priority over fetch. Each transaction ends in a single
// completion pulse to its owner, with Err raised for misaligned accesses or RAM timeouts.
module ram_access_arbiter #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              FReq,
    input  logic [ADDR_W-1:0] FAddr,
    output logic [31:0]       FData,
    output logic              FMoc,
    input  logic              DReq,
    input  logic              DRW,
    input  logic [1:0]        DSize,
    input  logic [ADDR_W-1:0] DAddr,
    input  logic [31:0]       DWData,
    output logic [31:0]       DRData,
    output logic              DMoc,
    output logic              MFA,
    output logic              MRW,
    output logic [1:0]        MSize,
    output logic [ADDR_W-1:0] MAddr,
    output logic [31:0]       MWData,
    input  logic [31:0]       MRData,
    input  logic              MMoc,
    output logic              Busy,
    output logic              Owner,
    output logic              Err
);

    localparam logic [7:0] TimeoutC = 8'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              mfa_q, mfa_d;
    logic              mrw_q, mrw_d;
    logic [1:0]        msize_q, msize_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic [31:0]       mwdata_q, mwdata_d;
    logic [31:0]       fdata_q, fdata_d;
    logic [31:0]       drdata_q, drdata_d;
    logic              fmoc_q, fmoc_d;
    logic              dmoc_q, dmoc_d;
    logic              busy_q, busy_d;
    logic              owner_q, owner_d;
    logic              err_q, err_d;

    logic              req_any;
    logic              grant_data;
    logic [ADDR_W-1:0] g_addr;
    logic [1:0]        g_size;
    logic              g_rw;
    logic              g_illegal;
    logic [7:0]        cnt_inc;

    // Grant decode: pick the winning requester and check its alignment.
    always_comb begin
        req_any    = DReq | FReq;
        grant_data = DReq;
        g_addr     = DReq ? DAddr : FAddr;
        g_size     = DReq ? DSize : 2'b10;
        g_rw       = DReq ? DRW : 1'b1;
        g_illegal  = 1'b0;
        unique case (g_size)
            2'b00:   g_illegal = 1'b0;
            2'b01:   g_illegal = g_addr[0];
            2'b10:   g_illegal = |g_addr[1:0];
            default: g_illegal = 1'b1;
        endcase
    end

    // Next-state and registered-output logic for the IDLE/ACCESS/RESP sequence.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mfa_d    = mfa_q;
        mrw_d    = mrw_q;
        msize_d  = msize_q;
        maddr_d  = maddr_q;
        mwdata_d = mwdata_q;
        fdata_d  = fdata_q;
        drdata_d = drdata_q;
        busy_d   = busy_q;
        owner_d  = owner_q;
        // Completion pulses and Err are only ever high for the single RESP cycle.
        fmoc_d   = 1'b0;
        dmoc_d   = 1'b0;
        err_d    = 1'b0;
        cnt_inc  = cnt_q + 8'd1;

        unique case (state_q)
            StIdle: begin
                if (req_any) begin
                    owner_d = grant_data;
                    maddr_d = g_addr;
                    msize_d = g_size;
                    mrw_d   = g_rw;
                    if (grant_data) begin
                        mwdata_d = DWData;
                    end
                    busy_d = 1'b1;
                    if (g_illegal) begin
                        // Misaligned: skip the RAM entirely and fail straight away.
                        state_d = StResp;
                        err_d   = 1'b1;
                        if (grant_data) begin
                            drdata_d = 32'd0;
                            dmoc_d   = 1'b1;
                        end else begin
                            fdata_d = 32'd0;
                            fmoc_d  = 1'b1;
                        end
                    end else begin
                        state_d = StAccess;
                        mfa_d   = 1'b1;
                        cnt_d   = 8'd0;
                    end
                end
            end
            StAccess: begin
                if (MMoc) begin
                    state_d = StResp;
                    mfa_d   = 1'b0;
                    if (owner_q) begin
                        drdata_d = MRData;
                        dmoc_d   = 1'b1;
                    end else begin
                        fdata_d = MRData;
                        fmoc_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TimeoutC) begin
                        state_d = StResp;
                        mfa_d   = 1'b0;
                        err_d   = 1'b1;
                        if (owner_q) begin
                            drdata_d = 32'd0;
                            dmoc_d   = 1'b1;
                        end else begin
                            fdata_d = 32'd0;
                            fmoc_d  = 1'b1;
                        end
                    end
                end
            end
            StResp: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = StIdle;
                mfa_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q  <= StIdle;
            cnt_q    <= 8'd0;
            mfa_q    <= 1'b0;
            mrw_q    <= 1'b0;
            msize_q  <= 2'b00;
            maddr_q  <= '0;
            mwdata_q <= 32'd0;
            fdata_q  <= 32'd0;
            drdata_q <= 32'd0;
            fmoc_q   <= 1'b0;
            dmoc_q   <= 1'b0;
            busy_q   <= 1'b0;
            owner_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mfa_q    <= mfa_d;
            mrw_q    <= mrw_d;
            msize_q  <= msize_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
            fdata_q  <= fdata_d;
            drdata_q <= drdata_d;
            fmoc_q   <= fmoc_d;
            dmoc_q   <= dmoc_d;
            busy_q   <= busy_d;
            owner_q  <= owner_d;
            err_q    <= err_d;
        end
    end

    assign MFA    = mfa_q;
    assign MRW    = mrw_q;
    assign MSize  = msize_q;
    assign MAddr  = maddr_q;
    assign MWData = mwdata_q;
    assign FData  = fdata_q;
    assign DRData = drdata_q;
    assign FMoc   = fmoc_q;
    assign DMoc   = dmoc_q;
    assign Busy   = busy_q;
    assign Owner  = owner_q;
    assign Err    = err_q;

endmodule

// File: doc/ram_access_arbiter.md
# ram_access_arbiter

Shares the single-port RAM between the control unit's instruction-fetch path and its load/store data path. Each requester holds a level request; the block grants one, drives the RAM's MFA/R-W/size/address/write-data, waits for the RAM's MOC, and returns a one-cycle completion pulse with read data. It sits between the control unit's fetch states (FIRST/SECOND/MOC) and load/store states (EIGHTEENTH, THIRTY_SEVENTH) and the RAM. It adds timeout and alignment error reporting.

## Interface
- ADDR_W, 8, RAM byte-address width
- TIMEOUT, 15, max ACCESS cycles waiting for MMoc before abort (1..255)
- Clk  in  1  clock, all state changes on rising edge
- Reset  in  1  synchronous, active-low reset
- FReq  in  1  fetch request, level, word read only
- FAddr  in  ADDR_W  fetch byte address
- FData  out  32  fetch read data, valid with FMoc
- FMoc  out  1  fetch complete, one-cycle pulse
- DReq  in  1  data request, level
- DRW  in  1  1 = read, 0 = write
- DSize  in  2  00 byte, 01 halfword, 10 word, 11 reserved
- DAddr  in  ADDR_W  data byte address
- DWData  in  32  write data, right-justified
- DRData  out  32  data read data, valid with DMoc
- DMoc  out  1  data complete, one-cycle pulse
- MFA  out  1  RAM function activate
- MRW  out  1  RAM read/write, 1 = read
- MSize  out  2  RAM access size
- MAddr  out  ADDR_W  RAM address
- MWData  out  32  RAM write data
- MRData  in  32  RAM read data
- MMoc  in  1  RAM memory-operation-complete
- Busy  out  1  high in ACCESS and RESP
- Owner  out  1  0 = fetch, 1 = data; holds last grant
- Err  out  1  pulse with FMoc/DMoc when transaction failed

## Operation
- States: IDLE, ACCESS, RESP. All outputs registered.
- IDLE: if DReq, grant data; else if FReq, grant fetch (fixed priority data > fetch). On grant, latch address, RW (fetch forces 1), size (fetch forces 10), write data, set Owner.
- Alignment check in IDLE on grant: word needs addr[1:0]=00, halfword addr[0]=0, size 11 always illegal. Illegal: no RAM access, go to RESP with Err=1, read data 0.
- Legal grant -> ACCESS: MFA=1 and M* driven from latched values, held stable for the whole state; wait counter cleared.
- ACCESS: MMoc=1 sampled -> latch MRData into requester's data register, go RESP. Else counter+1; counter reaching TIMEOUT -> go RESP with Err=1, data 0. MFA drops on the edge leaving ACCESS.
- RESP: MFA=0; pulse FMoc or DMoc (per Owner) exactly one cycle, Err with it if failed; then IDLE.
- Requester must drop Req by the edge ending its Moc cycle; Req still high in the following IDLE is a new request.
- Requests arriving while not IDLE wait; no queueing beyond the level request. Other requester's data/Moc outputs untouched.
- Read data passed unchanged (RAM performs size zero-extension). Write data passed unchanged.
- MMoc outside ACCESS ignored.

## Timing
- Reset (Reset=0 at rising edge): IDLE; MFA, MRW, MSize, MAddr, MWData, FData, DRData, FMoc, DMoc, Err, Busy, Owner all 0; counter 0; any in-flight transaction discarded, no Moc issued.
- Min latency: Req high in IDLE cycle 0 -> ACCESS cycle 1 (MMoc=1 in cycle 1) -> RESP cycle 2, Moc high in cycle 2 -> IDLE cycle 3. Back-to-back transactions every 3 cycles.
- Alignment error: Req cycle 0 -> RESP cycle 1 with Moc+Err.
- Timeout: MFA high exactly TIMEOUT cycles, Moc+Err in following cycle.
- Simultaneous FReq and DReq in IDLE: data granted; fetch granted in next IDLE if still held.

## Test plan
- Reset then FReq, FAddr=0x04, RAM MMoc after 3 cycles, MRData=0xE3A01005 -> MFA high 3 cycles, MRW=1, MSize=10, FMoc one cycle with FData=0xE3A01005, Err=0.
- DReq write, DSize=00, DAddr=0x13, DWData=0x000000AB -> MRW=0, MSize=00, MAddr=0x13, MWData=0xAB, DMoc pulse, FMoc stays 0.
- FReq and DReq asserted same cycle -> DMoc first, Owner=1; FMoc 3+ cycles later, Owner=0.
- DReq word at DAddr=0x06 -> MFA never high, DMoc and Err high cycle 1, DRData=0.
- MMoc held 0, TIMEOUT=15 -> MFA high 15 cycles, then DMoc+Err, back to IDLE.
- Reset low mid-ACCESS -> next cycle MFA=0, Busy=0, no Moc; subsequent FReq completes normally.
